// File: rtl/vid_timing_gen.sv
// vid_timing_gen: programmable video timing source.
// Generates vsync/hsync/de, pixel coordinates and a frame_start pulse from
// free-running h/v counters. Start and stop are aligned to frame boundaries.
// Optional macro VTG_PATTERN_EN enables a 32x32 checkerboard on img_y;
// without it img_y is tied to zero.
module vid_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [7:0]  img_y,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  logic        en_reg;
  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [11:0] h_cnt_reg;
  logic [11:0] v_cnt_reg;

  logic h_last;
  logic frame_last;
  logic active;
  logic de_next;
  logic hs_next;
  logic vs_next;

  assign h_last     = (h_cnt_reg == H_LAST);
  assign frame_last = h_last && (v_cnt_reg == V_LAST);
  assign active     = (state_reg != S_IDLE);
  assign de_next    = active && (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
  assign hs_next    = active && (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
  assign vs_next    = active && (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);

  // Register the run request so the FSM sees a clean, sampled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_reg <= 1'b0;
    else        en_reg <= en;
  end

  // Frame-aligned run/stop control. A stop request lets the current frame
  // finish; a request arriving exactly at the last frame cycle goes straight
  // to IDLE so no extra frame is started.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (en_reg) state_next = S_RUN;
      S_RUN: begin
        if (!en_reg) state_next = frame_last ? S_IDLE : S_STOP;
      end
      S_STOP: begin
        if (en_reg)          state_next = S_RUN;
        else if (frame_last) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // h/v counters: held at zero while idle, advance with wrap otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (!active) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_last) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? 12'd0 : v_cnt_reg + 12'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 12'd1;
    end
  end

  // Registered decode of the current counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= SYNC_OFF;
      post_frame_hsync <= SYNC_OFF;
      post_frame_de    <= 1'b0;
      pix_x            <= '0;
      pix_y            <= '0;
      frame_start      <= 1'b0;
      busy             <= 1'b0;
    end else begin
      post_frame_vsync <= vs_next ? SYNC_ON : SYNC_OFF;
      post_frame_hsync <= hs_next ? SYNC_ON : SYNC_OFF;
      post_frame_de    <= de_next;
      pix_x            <= de_next ? h_cnt_reg : 12'd0;
      pix_y            <= de_next ? v_cnt_reg : 12'd0;
      frame_start      <= (state_reg == S_RUN) && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
      busy             <= active;
    end
  end

`ifdef VTG_PATTERN_EN
  // Checkerboard test pattern, registered alongside de.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) img_y <= 8'd0;
    else        img_y <= (de_next && (h_cnt_reg[5] ^ v_cnt_reg[5])) ? 8'd255 : 8'd0;
  end
`else
  assign img_y = 8'd0;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// tb_vid_timing_gen: directed bench for vid_timing_gen.
// Small-timing instance covers counters, sync/de decode, start/stop and reset;
// a default-timing instance covers the img_y test pattern.
module tb_vid_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en_def = 1'b0;

  logic        vsync, hsync, de, fs, bsy;
  logic [7:0]  img;
  logic [11:0] px, py;

  logic        d_vsync, d_hsync, d_de, d_fs, d_bsy;
  logic [7:0]  d_img;
  logic [11:0] d_px, d_py;

  always #5 clk = ~clk;

  vid_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .post_frame_vsync(vsync), .post_frame_hsync(hsync), .post_frame_de(de),
    .img_y(img), .pix_x(px), .pix_y(py), .frame_start(fs), .busy(bsy)
  );

  vid_timing_gen u_def (
    .clk(clk), .rst_n(rst_n), .en(en_def),
    .post_frame_vsync(d_vsync), .post_frame_hsync(d_hsync), .post_frame_de(d_de),
    .img_y(d_img), .pix_x(d_px), .pix_y(d_py), .frame_start(d_fs), .busy(d_bsy)
  );

`ifdef VTG_PATTERN_EN
  localparam logic [7:0] PAT_HI = 8'd255;
`else
  localparam logic [7:0] PAT_HI = 8'd0;
`endif

  localparam logic [36:0] IDLE_V = '0;

  logic [36:0] obs_v;
  logic [36:0] def_v;
  assign obs_v = {vsync, hsync, de, fs, bsy, img, px, py};
  assign def_v = {d_vsync, d_hsync, d_de, d_fs, d_bsy, d_img, d_px, d_py};

  int checks = 0;
  int errors = 0;
  int de_cnt = 0;

  task automatic chk(input string tag, input logic [36:0] observed, input logic [36:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Expected small-timing output for output cycle t of a running frame stream.
  function automatic logic [36:0] model(input int t);
    int h, v;
    logic e_de, e_hs, e_vs, e_fs;
    h    = t % 8;
    v    = (t / 8) % 6;
    e_de = (h < 4) && (v < 3);
    e_hs = (h == 5) || (h == 6);
    e_vs = (v == 4);
    e_fs = (h == 0) && (v == 0);
    return {e_vs, e_hs, e_de, e_fs, 1'b1, 8'd0,
            e_de ? 12'(h) : 12'd0, e_de ? 12'(v) : 12'd0};
  endfunction

  initial begin
    // Reset with en low: everything idle.
    repeat (3) @(negedge clk);
    chk("reset_idle", obs_v, IDLE_V);
    chk("reset_idle_def", def_v, IDLE_V);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_release", obs_v, IDLE_V);
    end
    $display("phase reset/idle done");

    // Start: two idle cycles of latency, then frame_start with pix (0,0).
    en = 1'b1;
    @(negedge clk); chk("start_lat_k", obs_v, IDLE_V);
    @(negedge clk); chk("start_lat_k1", obs_v, IDLE_V);
    @(negedge clk);
    // Two full frames, then drop en during line 1 of the third.
    for (int t = 0; t < 144; t++) begin
      if (t == 106) en = 1'b0;
      chk("run_stop", obs_v, model(t));
      if (t >= 96 && de) de_cnt++;
      @(negedge clk);
    end
    chk("stop_frame_de_count", 37'(de_cnt), 37'd12);
    for (int i = 0; i < 20; i++) begin
      chk("stopped_idle", obs_v, IDLE_V);
      @(negedge clk);
    end
    $display("phase run/stop done");

    // Restart, stop in line 1, resume in line 3: no gap between frames.
    en = 1'b1;
    @(negedge clk); chk("restart_lat_k", obs_v, IDLE_V);
    @(negedge clk); chk("restart_lat_k1", obs_v, IDLE_V);
    @(negedge clk);
    for (int t = 0; t < 154; t++) begin
      if (t == 10) en = 1'b0;
      if (t == 30) en = 1'b1;
      chk("resume", obs_v, model(t));
      @(negedge clk);
    end
    $display("phase resume done");

    // Asynchronous reset mid-line while running.
    #1 rst_n = 1'b0;
    #1 chk("async_reset_now", obs_v, IDLE_V);
    @(negedge clk); chk("reset_held", obs_v, IDLE_V);
    rst_n = 1'b1;
    @(negedge clk); chk("post_reset_lat_k", obs_v, IDLE_V);
    @(negedge clk); chk("post_reset_lat_k1", obs_v, IDLE_V);
    @(negedge clk);
    for (int t = 0; t < 16; t++) begin
      chk("post_reset_run", obs_v, model(t));
      @(negedge clk);
    end
    en = 1'b0;
    $display("phase reset mid-line done");

    // Pattern on default timing.
    en_def = 1'b1;
    @(negedge clk); chk("def_lat_k", def_v, IDLE_V);
    @(negedge clk); chk("def_lat_k1", def_v, IDLE_V);
    @(negedge clk);
    for (int t = 0; t <= 800 * 32 + 32; t++) begin
      if (t == 0)
        chk("pat_0_0", {4'd0, d_de, d_img, d_px, d_py}, {4'd0, 1'b1, 8'd0, 12'd0, 12'd0});
      if (t == 32)
        chk("pat_32_0", {4'd0, d_de, d_img, d_px, d_py}, {4'd0, 1'b1, PAT_HI, 12'd32, 12'd0});
      if (t == 700)
        chk("pat_outside_de", {4'd0, d_de, d_img, d_px, d_py}, {4'd0, 1'b0, 8'd0, 12'd0, 12'd0});
      if (t == 800 * 32)
        chk("pat_0_32", {4'd0, d_de, d_img, d_px, d_py}, {4'd0, 1'b1, PAT_HI, 12'd0, 12'd32});
      if (t == 800 * 32 + 32)
        chk("pat_32_32", {4'd0, d_de, d_img, d_px, d_py}, {4'd0, 1'b1, 8'd0, 12'd32, 12'd32});
      @(negedge clk);
    end
    $display("phase pattern done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
